// File: rtl/tape_pkg.sv
// Shared definitions for the cassette capture path: framing states, cell sizes
// and the half-period thresholds derived from the system clock rate.
package tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_HUNT,
    ST_DATA,
    ST_STOP
  } tape_state_e;

  localparam int unsigned CNT_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Cell sizes in short-half units (one 2400 Hz half = 1 unit)
  localparam logic [4:0] CELL_1200 = 5'd4;
  localparam logic [4:0] CELL_300  = 5'd16;

  function automatic logic [CNT_W-1:0] glitch_ticks(input int unsigned clk_hz);
    return CNT_W'(clk_hz / 12000);
  endfunction

  function automatic logic [CNT_W-1:0] short_max_ticks(input int unsigned clk_hz);
    return CNT_W'(clk_hz / 3200);
  endfunction

  function automatic logic [CNT_W-1:0] carrier_ticks(input int unsigned clk_hz);
    return CNT_W'(clk_hz / 800);
  endfunction

endpackage

// File: rtl/fsk_halfcycle.sv
// Front end: synchronises the cassette level, times each half period and
// classifies it as short (2400 Hz) or long (1200 Hz); also flags carrier loss.
module fsk_halfcycle
  import tape_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cass_i,
  output logic half_valid_o,
  output logic half_long_o,
  output logic carrier_lost_o
);

  localparam logic [CNT_W-1:0] GLITCH_MIN = glitch_ticks(CLK_HZ);
  localparam logic [CNT_W-1:0] SHORT_MAX  = short_max_ticks(CLK_HZ);
  localparam logic [CNT_W-1:0] CARRIER    = carrier_ticks(CLK_HZ);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_valid_q, half_valid_d;
  logic             half_long_q, half_long_d;
  logic             edge_det, restart;

  always_comb begin
    edge_det     = sync2_q ^ prev_q;
    // Edges arriving too soon after the last accepted one are glitches;
    // the running count is kept so the true half still measures correctly.
    restart      = edge_det && (cnt_q >= GLITCH_MIN);
    half_valid_d = restart;
    half_long_d  = restart ? (cnt_q > SHORT_MAX) : half_long_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      half_valid_q <= 1'b0;
      half_long_q  <= 1'b0;
    end else begin
      sync1_q      <= cass_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      half_valid_q <= half_valid_d;
      half_long_q  <= half_long_d;
    end
  end

  assign half_valid_o   = half_valid_q;
  assign half_long_o    = half_long_q;
  assign carrier_lost_o = (cnt_q >= CARRIER);

endmodule

// File: rtl/tape_capture.sv
// CUTS cassette decoder: groups classified half periods into bit cells, frames
// bytes after a leader lock and writes them sequentially into a capture buffer.
module tape_capture
  import tape_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LEADER_MIN = 16
) (
  input  logic              CLK12,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              BAUD300,
  input  logic              CASS_IN,
  input  logic              CLEAR,
  output logic [ADDR_W-1:0] BUF_ADDR,
  output logic [7:0]        BUF_DATA,
  output logic              BUF_WE,
  output logic [ADDR_W-1:0] BYTE_CNT,
  output logic              OVERFLOW,
  output logic              FRAME_ERR,
  output logic              SYNCED
);

  localparam int unsigned LEAD_W = $clog2(LEADER_MIN + 1);

  logic half_valid, half_long, carrier_lost;

  fsk_halfcycle #(.CLK_HZ(CLK_HZ)) u_fsk (
    .clk_i          (CLK12),
    .rst_i          (RESET),
    .cass_i         (CASS_IN),
    .half_valid_o   (half_valid),
    .half_long_o    (half_long),
    .carrier_lost_o (carrier_lost)
  );

  tape_state_e       state_q, state_d;
  logic [4:0]        short_w_q, short_w_d, long_w_q, long_w_d;
  logic [LEAD_W-1:0] lead_cnt_q, lead_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              baud300_q, baud300_d;
  logic              synced_q, synced_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;

  logic [4:0] target, weight, total, s_w, l_w;
  logic       cell_done, cell_bit, carry;
  logic       emit;

  always_comb begin
    target    = baud300_q ? CELL_300 : CELL_1200;
    weight    = half_long ? 5'd2 : 5'd1;
    total     = short_w_q + long_w_q + weight;
    cell_done = half_valid && (total >= target);
    // A long half landing one unit short of the target spills one unit over.
    carry     = (total > target);
    s_w       = short_w_q + (half_long ? 5'd0 : 5'd1);
    l_w       = long_w_q + (half_long ? (carry ? 5'd1 : 5'd2) : 5'd0);
    cell_bit  = (s_w > l_w);
  end

  always_comb begin
    state_d     = state_q;
    short_w_d   = short_w_q;
    long_w_d    = long_w_q;
    lead_cnt_d  = lead_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    baud300_d   = baud300_q;
    synced_d    = synced_q;
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    emit        = 1'b0;

    if (state_q == ST_IDLE) begin
      baud300_d = BAUD300;
    end

    if (!ENABLE || (state_q != ST_IDLE && carrier_lost)) begin
      state_d    = ST_IDLE;
      short_w_d  = '0;
      long_w_d   = '0;
      lead_cnt_d = '0;
      bit_cnt_d  = '0;
      synced_d   = 1'b0;
    end else if (half_valid) begin
      if (state_q == ST_IDLE) begin
        // The first edge only marks where the tone begins; its half is not timed.
        state_d = ST_LEADER;
      end else begin
        if (cell_done) begin
          short_w_d = '0;
          long_w_d  = carry ? 5'd1 : 5'd0;
        end else begin
          short_w_d = s_w;
          long_w_d  = l_w;
        end
        if (cell_done) begin
          case (state_q)
            ST_LEADER: begin
              if (!cell_bit) begin
                lead_cnt_d = '0;
              end else if (lead_cnt_q == LEAD_W'(LEADER_MIN - 1)) begin
                lead_cnt_d = '0;
                synced_d   = 1'b1;
                state_d    = ST_HUNT;
              end else begin
                lead_cnt_d = lead_cnt_q + 1'b1;
              end
            end
            ST_HUNT: begin
              if (!cell_bit) begin
                bit_cnt_d = '0;
                state_d   = ST_DATA;
              end
            end
            ST_DATA: begin
              shift_d   = {cell_bit, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d = ST_STOP;
              end
            end
            ST_STOP: begin
              if (cell_bit) begin
                emit    = 1'b1;
                state_d = ST_HUNT;
              end else begin
                frame_err_d = 1'b1;
                lead_cnt_d  = '0;
                synced_d    = 1'b0;
                state_d     = ST_LEADER;
              end
            end
            default: ;
          endcase
        end
      end
    end

    if (emit) begin
      if (byte_cnt_q != '1) begin
        we_d       = 1'b1;
        addr_d     = byte_cnt_q;
        data_d     = shift_q;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Applied last so a coincident write still lands at the old address.
    if (CLEAR) begin
      byte_cnt_d  = '0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK12 or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      short_w_q   <= '0;
      long_w_q    <= '0;
      lead_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      baud300_q   <= 1'b0;
      synced_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      short_w_q   <= short_w_d;
      long_w_q    <= long_w_d;
      lead_cnt_q  <= lead_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      baud300_q   <= baud300_d;
      synced_q    <= synced_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
    end
  end

  assign BUF_ADDR  = addr_q;
  assign BUF_DATA  = data_q;
  assign BUF_WE    = we_q;
  assign BYTE_CNT  = byte_cnt_q;
  assign OVERFLOW  = overflow_q;
  assign FRAME_ERR = frame_err_q;
  assign SYNCED    = synced_q;

endmodule

// File: tb/tb_tape_capture.sv
// Bench for tape_capture: synthesises CUTS tones bit by bit and compares the
// captured writes and status against a byte-level model of the framing rules.
module tb_tape_capture;

  localparam int unsigned CLK_HZ     = 120_000;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned LEADER_MIN = 16;
  localparam int SHORT_T  = CLK_HZ / 4800;
  localparam int LONG_T   = CLK_HZ / 2400;
  localparam int QUIET_T  = CLK_HZ / 800 + 60;
  localparam int GLITCH_T = 4;
  localparam int MAXCNT   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst, enable, baud300, cass, clear;
  logic [ADDR_W-1:0] buf_addr, byte_cnt;
  logic [7:0]        buf_data;
  logic              buf_we, overflow, frame_err, synced;

  always #5 clk = ~clk;

  tape_capture #(.CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .LEADER_MIN(LEADER_MIN)) dut (
    .CLK12     (clk),
    .RESET     (rst),
    .ENABLE    (enable),
    .BAUD300   (baud300),
    .CASS_IN   (cass),
    .CLEAR     (clear),
    .BUF_ADDR  (buf_addr),
    .BUF_DATA  (buf_data),
    .BUF_WE    (buf_we),
    .BYTE_CNT  (byte_cnt),
    .OVERFLOW  (overflow),
    .FRAME_ERR (frame_err),
    .SYNCED    (synced)
  );

  int checks = 0;
  int failures = 0;

  // Byte-level model of the capture buffer state
  int          m_cnt  = 0;
  bit          m_ovf  = 1'b0;
  bit          m_ferr = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      got_q.push_back({16'd0, 8'(buf_addr), buf_data});
      $display("wr addr=%0d data=%02h", buf_addr, buf_data);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input int t, input bit glitch);
    if (glitch) begin
      wait_ticks(1);
      cass = ~cass;
      wait_ticks(GLITCH_T);
      cass = ~cass;
      wait_ticks(t - 1 - GLITCH_T);
    end else begin
      wait_ticks(t);
    end
    cass = ~cass;
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    int units;
    units = baud300 ? 16 : 4;
    if (b) begin
      for (int i = 0; i < units; i++) half(SHORT_T, glitch && i == 0);
    end else begin
      for (int i = 0; i < units / 2; i++) half(LONG_T, glitch && i == 0);
    end
  endtask

  task automatic send_leader(input int n, input bit glitchy);
    for (int i = 0; i < n; i++) send_bit(1'b1, glitchy && (i % 3 == 1));
  endtask

  task automatic model_emit(input logic [7:0] d);
    if (m_cnt < MAXCNT) begin
      exp_q.push_back({16'd0, 8'(m_cnt), d});
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nstop, input bit stop_ok);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    if (stop_ok) begin
      for (int i = 0; i < nstop; i++) send_bit(1'b1, 1'b0);
      model_emit(d);
    end else begin
      send_bit(1'b0, 1'b0);
      m_ferr = 1'b1;
    end
  endtask

  task automatic start_tone();
    wait_ticks(2);
    cass = ~cass;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic end_tone(input string tag, input bit exp_sync);
    int n;
    wait_ticks(10);
    check_val({tag, "_synced"}, 32'(synced), 32'(exp_sync));
    wait_ticks(QUIET_T);
    check_val({tag, "_lost"}, 32'(synced), 32'd0);
    check_val({tag, "_nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    check_val({tag, "_cnt"}, 32'(byte_cnt), m_cnt);
    check_val({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int         nb;
    bit         ok, last_ok;

    rst = 1'b1; enable = 1'b1; baud300 = 1'b0; cass = 1'b0; clear = 1'b0;
    wait_ticks(5);
    check_val("rst_we", 32'(buf_we), 0);
    check_val("rst_addr", 32'(buf_addr), 0);
    check_val("rst_data", 32'(buf_data), 0);
    check_val("rst_cnt", 32'(byte_cnt), 0);
    check_val("rst_ovf", 32'(overflow), 0);
    check_val("rst_ferr", 32'(frame_err), 0);
    check_val("rst_sync", 32'(synced), 0);
    rst = 1'b0;
    wait_ticks(QUIET_T);

    // 1200 baud single byte, two stop bits
    start_tone();
    send_leader(32, 1'b0);
    send_frame(8'hA5, 2, 1'b1);
    end_tone("a5", 1'b1);

    // 300 baud, two bytes
    do_clear();
    baud300 = 1'b1;
    wait_ticks(3);
    start_tone();
    send_leader(18, 1'b0);
    send_frame(8'h00, 2, 1'b1);
    send_frame(8'hFF, 1, 1'b1);
    end_tone("b300", 1'b1);
    baud300 = 1'b0;
    wait_ticks(3);

    // Bad stop bit, then a fresh leader and byte
    do_clear();
    start_tone();
    send_leader(18, 1'b0);
    send_frame(8'h3C, 1, 1'b0);
    wait_ticks(10);
    check_val("ferr_set", 32'(frame_err), 32'd1);
    check_val("ferr_sync", 32'(synced), 32'd0);
    check_val("ferr_nowr", got_q.size(), 0);
    send_leader(18, 1'b0);
    send_frame(8'h11, 1, 1'b1);
    end_tone("ferr", 1'b1);

    // Short glitches inside the leader
    do_clear();
    start_tone();
    send_leader(24, 1'b1);
    send_frame(8'h5A, 1, 1'b1);
    end_tone("glitch", 1'b1);

    // ENABLE dropped mid-byte
    do_clear();
    start_tone();
    send_leader(18, 1'b0);
    d = 8'($urandom);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    enable = 1'b0;
    wait_ticks(QUIET_T);
    enable = 1'b1;
    start_tone();
    send_leader(18, 1'b0);
    send_frame(8'h77, 1, 1'b1);
    end_tone("enable", 1'b1);

    // Buffer fills after 3 bytes with a 2-bit address
    do_clear();
    start_tone();
    send_leader(18, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), $urandom_range(1, 2), 1'b1);
    end_tone("ovf", 1'b1);
    do_clear();
    wait_ticks(2);
    check_val("clr_cnt", 32'(byte_cnt), 0);
    check_val("clr_ovf", 32'(overflow), 0);

    // Randomised runs
    for (int r = 0; r < 2; r++) begin
      if ($urandom_range(0, 1) == 1) do_clear();
      start_tone();
      send_leader($urandom_range(18, 22), 1'($urandom_range(0, 1)));
      nb = $urandom_range(1, 3);
      last_ok = 1'b1;
      for (int i = 0; i < nb; i++) begin
        ok = ($urandom_range(0, 4) != 0);
        send_frame(8'($urandom), $urandom_range(1, 2), ok);
        if (!ok) send_leader(18, 1'b0);
        last_ok = ok;
      end
      if (!last_ok) send_frame(8'($urandom), 1, 1'b1);
      end_tone($sformatf("rnd%0d", r), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
